// File: rtl/rx_input_fifo_pkg.sv
// Shared constants for the serial receiver input path.
// Word width matches the receiver data_out width.
package rx_input_fifo_pkg;

    localparam int RX_DATA_W     = 10;
    localparam int RX_FIFO_DEPTH = 4;

endpackage

// File: rtl/rx_input_fifo_if.sv
// Receiver-side and core-side signals of the input FIFO.
// slave is the FIFO view, master the driving environment.
interface rx_input_fifo_if
    import rx_input_fifo_pkg::*;
#(
    parameter int DATA_W = RX_DATA_W,
    parameter int AW     = $clog2(RX_FIFO_DEPTH)
);

    logic              rx_enable;
    logic              rx_done;
    logic [DATA_W-1:0] rx_data;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ack;
    logic              flush;
    logic [AW:0]       count;
    logic              overflow;

    modport slave (
        input  rx_done, rx_data, rd_ack, flush,
        output rx_enable, rd_valid, rd_data, count, overflow
    );

    modport master (
        output rx_done, rx_data, rd_ack, flush,
        input  rx_enable, rd_valid, rd_data, count, overflow
    );

endinterface

// File: rtl/rx_input_fifo_sync_fifo_sa.sv
// Generic show-ahead synchronous FIFO.
// Head is presented combinationally, forced to 0 when empty.
module sync_fifo_sa
    import rx_input_fifo_pkg::*;
#(
    parameter int DATA_W = RX_DATA_W,
    parameter int DEPTH  = RX_FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              valid_o,
    output logic              full_o,
    output logic [AW:0]       count_o,
    output logic [AW:0]       count_next_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_push, do_pop;

    assign valid_o      = (count_q != '0);
    assign full_o       = (count_q == FULL_CNT);
    assign do_pop       = pop_i & valid_o;
    assign do_push      = push_i & (~full_o | do_pop);
    assign rdata_o      = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o      = count_q;
    assign count_next_o = count_d;

    // Pointer and occupancy update; flush clears everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since reads are gated.
    always_ff @(posedge clk) begin
        if (do_push & ~flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/rx_input_fifo.sv
// Receiver input buffer: done edge capture, enable policy,
// flush stretching and sticky overflow around a show-ahead FIFO.
module rx_input_fifo
    import rx_input_fifo_pkg::*;
#(
    parameter int DATA_W = RX_DATA_W,
    parameter int DEPTH  = RX_FIFO_DEPTH
) (
    input logic            clk,
    input logic            rst,
    rx_input_fifo_if.slave bus
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic        done_q, done_d;
    logic        flush_q, flush_d;
    logic        ovf_q, ovf_d;
    logic        en_q, en_d;
    logic        push, pop, full;
    logic [AW:0] count_next;

    assign push = bus.rx_done & ~done_q;
    assign pop  = bus.rd_ack & bus.rd_valid;

    sync_fifo_sa #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .pop_i        (bus.rd_ack),
        .flush_i      (bus.flush),
        .wdata_i      (bus.rx_data),
        .rdata_o      (bus.rd_data),
        .valid_o      (bus.rd_valid),
        .full_o       (full),
        .count_o      (bus.count),
        .count_next_o (count_next)
    );

    // Next-state: enable only with room and outside the 2-cycle flush window.
    always_comb begin
        done_d  = bus.rx_done;
        flush_d = bus.flush;
        ovf_d   = ovf_q | (push & full & ~pop);
        en_d    = ~flush_q & (count_next < FULL_CNT);
        if (bus.flush) begin
            done_d = 1'b0;
            ovf_d  = 1'b0;
            en_d   = 1'b0;
        end
    end

    // Wrapper state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q  <= 1'b0;
            flush_q <= 1'b0;
            ovf_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            done_q  <= done_d;
            flush_q <= flush_d;
            ovf_q   <= ovf_d;
            en_q    <= en_d;
        end
    end

    assign bus.rx_enable = en_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_rx_input_fifo.sv
// Randomized scoreboard bench for rx_input_fifo against a
// queue-based reference model.
module tb_rx_input_fifo;
    import rx_input_fifo_pkg::*;

    localparam int DW    = RX_DATA_W;
    localparam int DEPTH = RX_FIFO_DEPTH;
    localparam int AW    = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b1;

    rx_input_fifo_if #(.DATA_W(DW), .AW(AW)) bus ();

    rx_input_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    logic [DW-1:0] m_q[$];
    logic [DW-1:0] sb_q[$];
    bit m_ovf  = 1'b0;
    bit m_en   = 1'b0;
    bit m_fq   = 1'b0;
    bit m_prev = 1'b0;
    int m_n;
    bit m_push, m_pop;

    // Reference model: one word per done rise, queue of DEPTH words.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            sb_q.delete();
            m_ovf = 0; m_en = 0; m_fq = 0; m_prev = 0;
        end else if (bus.flush) begin
            m_q.delete();
            sb_q.delete();
            m_ovf = 0; m_en = 0; m_fq = 1; m_prev = 0;
        end else begin
            m_n    = m_q.size();
            m_push = bus.rx_done && !m_prev;
            m_pop  = bus.rd_ack && (m_n > 0);
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
                if (m_n < DEPTH || m_pop) begin
                    m_q.push_back(bus.rx_data);
                    sb_q.push_back(bus.rx_data);
                end else begin
                    m_ovf = 1;
                end
            end
            m_en   = !m_fq && (m_q.size() < DEPTH);
            m_fq   = 0;
            m_prev = bus.rx_done;
        end
    end

    // Monitor: status every cycle, data whenever the core consumes.
    always @(negedge clk) begin
        chk("count", int'(bus.count), m_q.size());
        chk("rd_valid", int'(bus.rd_valid), int'(m_q.size() != 0));
        chk("rx_enable", int'(bus.rx_enable), int'(m_en));
        chk("overflow", int'(bus.overflow), int'(m_ovf));
        if (!bus.rd_valid) chk("rd_data_empty", int'(bus.rd_data), 0);
        if (bus.rd_valid && bus.rd_ack && !bus.flush && !rst) begin
            chk("sb_nonempty", int'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) chk("rd_data", int'(bus.rd_data), int'(sb_q.pop_front()));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        bus.rx_done = 1'b1;
        bus.rx_data = w;
        step();
        bus.rx_done = 1'b0;
        step();
    endtask

    int ack_div;

    initial begin
        bus.rx_done = 1'b0;
        bus.rx_data = '0;
        bus.rd_ack  = 1'b0;
        bus.flush   = 1'b0;
        step(3);
        chk("rst_enable", int'(bus.rx_enable), 0);
        rst = 1'b0;
        step(2);
        chk("enable_after_rst", int'(bus.rx_enable), 1);

        bus.rx_done = 1'b1;
        bus.rx_data = 10'h2A5;
        step(5);
        bus.rx_done = 1'b0;
        step();
        chk("single_count", int'(bus.count), 1);
        chk("single_data", int'(bus.rd_data), 'h2A5);
        bus.rd_ack = 1'b1;
        step();
        bus.rd_ack = 1'b0;
        step();
        chk("single_drain", int'(bus.count), 0);

        for (int i = 1; i <= 5; i++) push_word(DW'(i));
        chk("full_count", int'(bus.count), DEPTH);
        chk("full_ovf", int'(bus.overflow), 1);
        chk("full_enable", int'(bus.rx_enable), 0);
        bus.rd_ack = 1'b1;
        step();
        chk("enable_after_pop", int'(bus.rx_enable), 1);
        step(3);
        bus.rd_ack = 1'b0;
        step();

        push_word(10'h006);
        push_word(10'h007);
        for (int k = 0; k < 4; k++) begin
            bus.rx_done = 1'b1;
            bus.rx_data = DW'(8 + k);
            bus.rd_ack  = 1'b1;
            step();
            bus.rx_done = 1'b0;
            bus.rd_ack  = 1'b0;
            step();
            chk("pp_count", int'(bus.count), 2);
        end
        bus.rd_ack = 1'b1;
        step(2);
        bus.rd_ack = 1'b0;
        step();

        for (int i = 0; i < 3; i++) push_word(DW'(10'h100 + i));
        chk("pre_flush_ovf", int'(bus.overflow), 1);
        bus.flush   = 1'b1;
        bus.rx_done = 1'b1;
        bus.rx_data = 10'h3FF;
        step();
        bus.flush   = 1'b0;
        bus.rx_done = 1'b0;
        chk("flush_count", int'(bus.count), 0);
        chk("flush_ovf", int'(bus.overflow), 0);
        chk("flush_en0", int'(bus.rx_enable), 0);
        step();
        chk("flush_en1", int'(bus.rx_enable), 0);
        step();
        chk("flush_en2", int'(bus.rx_enable), 1);
        chk("flush_nostore", int'(bus.count), 0);

        push_word(10'h01A);
        push_word(10'h01B);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_count", int'(bus.count), 0);
        chk("arst_valid", int'(bus.rd_valid), 0);
        chk("arst_enable", int'(bus.rx_enable), 0);
        chk("arst_data", int'(bus.rd_data), 0);
        step(2);
        rst = 1'b0;
        step(2);
        chk("post_rst_count", int'(bus.count), 0);

        for (int ph = 0; ph < 2; ph++) begin
            ack_div = (ph == 0) ? 7 : 1;
            repeat (1500) begin
                if ($urandom_range(0, 3) == 0) bus.rx_done = ~bus.rx_done;
                bus.rx_data = DW'($urandom);
                bus.rd_ack  = ($urandom_range(0, ack_div) == 0);
                bus.flush   = ($urandom_range(0, 80) == 0);
                step();
            end
        end

        bus.rx_done = 1'b0;
        bus.flush   = 1'b0;
        bus.rd_ack  = 1'b1;
        step(DEPTH + 2);
        bus.rd_ack = 1'b0;
        step();
        chk("final_empty", int'(bus.count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rx_input_fifo.md
Name: rx_input_fifo

Overview:
- Downstream stage of the 2-wire serial receiver; sits between it and the core's input (',') operation.
- Keeps the receiver enabled while there is room and captures each completed 10-bit word on the receiver's done pulse.
- Buffers completed words in a small show-ahead FIFO and presents them to the core through a valid/ack read interface.
- Provides flush and a sticky overflow flag.

Parameters:
- DATA_W, 10, word width; must equal the receiver data_out width.
- DEPTH, 4, FIFO entries; power of two, 2 to 16.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- rx_enable  out  1  enable to receiver; low discards any partial word
- rx_done  in  1  receiver done level
- rx_data  in  DATA_W  receiver data; valid only while rx_done=1
- rd_valid  out  1  head entry available
- rd_data  out  DATA_W  head entry (show-ahead); 0 when empty
- rd_ack  in  1  consume head; ignored when rd_valid=0
- flush  in  1  synchronous clear of FIFO and receiver
- count  out  AW+1  occupied entries, 0..DEPTH
- overflow  out  1  sticky: a word was dropped because the FIFO was full

Behaviour:
- Reset (rst=1, async) values:
  - rx_enable=0, rd_valid=0, rd_data=0, count=0, overflow=0.
  - Pointers=0, done_q=0, flush_q=0.
- Push detection:
  - done_q registers rx_done every cycle.
  - push = rx_done & ~done_q, i.e. rising edge, exactly one push per word.
  - A level held across many cycles gives one push only.
  - rx_done falling, or dropping because enable went low, never pushes.
- Write: on a push edge, rx_data is written at wr_ptr, wr_ptr increments (wraps mod DEPTH) and count increments.
  - rd_valid=1 and rd_data show the word from the next cycle, i.e. 1-cycle latency from the sampled done rise.
- Read: when rd_ack=1 and rd_valid=1, rd_ptr increments (wraps) and count decrements.
  - rd_data shows the next entry from the following cycle; rd_data is combinational from storage[rd_ptr] gated by rd_valid.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - When empty, push+ack is impossible because rd_valid=0, so ack is ignored and the push lands.
- Full:
  - A push while count==DEPTH and no pop in the same cycle drops the word and sets overflow.
  - A push with a same-cycle pop while full is accepted.
- rx_enable (registered): next value = ~flush & (count_next < DEPTH).
  - It drops the cycle after the FIFO becomes full.
  - It re-asserts the cycle after a pop frees an entry.
- Flush:
  - pointers=0, count=0, overflow=0, done_q=0, rx_enable=0 for that cycle and the next.
  - flush_q forces one extra low cycle, guaranteeing the receiver clears its bit counter and done.
  - A push or ack in the flush cycle is discarded.
  - flush outranks everything except rst.
- Empty: rd_valid=0, rd_data=0, rd_ack has no effect, count stays 0 with no underflow wrap.
- Reset mid-word: the receiver sees enable=0, so the partial word is lost and no spurious push occurs after release, since done_q=0 and rx_done is also reset low.
- Width: count is AW+1 bits so it holds DEPTH exactly; pointers are AW bits and wrap naturally.
- No combinational path from rd_ack to rx_enable.

Decomposition:
- Shared package: RX_DATA_W=10 (shared with the receiver), default FIFO depth constant.
- One natural sub-module: sync_fifo_sa, a generic show-ahead synchronous FIFO with push/pop/flush/count.
- rx_input_fifo wraps it with done edge detection, the rx_enable policy, flush stretching and the overflow flag.

Test Plan:
- Reset then idle:
  - rst pulse → rx_enable=0 during rst, 1 one cycle after release.
  - count=0, rd_valid=0, rd_data=0.
- Single word:
  - rx_done rises with rx_data=10'h2A5 and stays high 5 cycles → exactly one push.
  - rd_valid=1 next cycle, rd_data=10'h2A5, count=1.
  - rd_ack → count=0, rd_valid=0.
- Fill to full with DEPTH=4:
  - Push 10'h001..10'h004 → count=4; rx_enable=0 the next cycle.
  - A fifth done edge with 10'h005 → dropped, overflow=1.
  - Reads return 001,002,003,004 in order; rx_enable=1 after the first read.
- Simultaneous push and pop at count=2 → count stays 2, order is preserved across the pointer wrap (write 6 words, read 6 words).
- Flush with count=3 and overflow=1:
  - flush → count=0, overflow=0, rd_valid=0.
  - rx_enable low for exactly 2 cycles.
  - A done edge in the flush cycle is not stored.
- Async reset mid-operation:
  - Assert rst between clock edges with count=2 → all outputs reset immediately without waiting for clk.
  - After release, a stale rx_done=0 produces no push.
